// File: rtl/nebula_pkg.sv
// rtl/nebula_pkg.sv - shared Nebula mesh types: flit format, flit kinds, packet request
package nebula_pkg;

    localparam int COORD_WIDTH     = 4;
    localparam int FLIT_DATA_WIDTH = 32;
    localparam int NUM_VCS         = 2;
    localparam int VC_W            = $clog2(NUM_VCS);
    localparam int PKT_ID_W        = 8;
    localparam int PKT_LEN_W       = 16;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_t;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_SEND = 1'b1
    } pkt_state_t;

    typedef struct packed {
        flit_type_t                 flit_type;
        logic [PKT_ID_W-1:0]        packet_id;
        logic [COORD_WIDTH-1:0]     src_x;
        logic [COORD_WIDTH-1:0]     src_y;
        logic [COORD_WIDTH-1:0]     dest_x;
        logic [COORD_WIDTH-1:0]     dest_y;
        logic [VC_W-1:0]            vc_id;
        logic [FLIT_DATA_WIDTH-1:0] payload;
    } noc_flit_t;

    // len doubles as the remaining-flit counter once the request is latched
    typedef struct packed {
        logic [COORD_WIDTH-1:0] dest_x;
        logic [COORD_WIDTH-1:0] dest_y;
        logic [VC_W-1:0]        vc;
        logic [PKT_LEN_W-1:0]   len;
    } pkt_req_t;

    function automatic flit_type_t flit_kind(input logic first, input logic last);
        if (first && last) return FLIT_SINGLE;
        else if (first)    return FLIT_HEAD;
        else if (last)     return FLIT_TAIL;
        else               return FLIT_BODY;
    endfunction

endpackage

// File: rtl/nebula_flit_out_reg.sv
// rtl/nebula_flit_out_reg.sv - one-entry valid/ready flit register with load-while-drain
module nebula_flit_out_reg
    import nebula_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  noc_flit_t load_flit,
    output logic      can_load,
    output logic      out_valid,
    input  logic      out_ready,
    output noc_flit_t out_flit
);

    logic      valid_q, valid_d;
    noc_flit_t flit_q, flit_d;

    always_comb begin
        valid_d = valid_q;
        flit_d  = flit_q;
        if (load) begin
            valid_d = 1'b1;
            flit_d  = load_flit;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            valid_q <= valid_d;
            flit_q  <= flit_d;
        end
    end

    assign can_load  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_flit  = flit_q;

endmodule

// File: rtl/nebula_local_packetizer.sv
// rtl/nebula_local_packetizer.sv - turns packet requests plus payload words into local-port flits
module nebula_local_packetizer
    import nebula_pkg::*;
#(
    parameter int MESH_SIZE_X   = 2,
    parameter int MESH_SIZE_Y   = 2,
    parameter int SRC_X         = 0,
    parameter int SRC_Y         = 0,
    parameter int MAX_PKT_FLITS = 16,
    localparam int LEN_W        = $clog2(MAX_PKT_FLITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [COORD_WIDTH-1:0]     req_dest_x,
    input  logic [COORD_WIDTH-1:0]     req_dest_y,
    input  logic [VC_W-1:0]            req_vc,
    input  logic [LEN_W-1:0]           req_len,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic [FLIT_DATA_WIDTH-1:0] data,
    output logic                       flit_out_valid,
    input  logic                       flit_out_ready,
    output noc_flit_t                  flit_out,
    output logic                       busy,
    output logic                       req_err,
    output logic [31:0]                pkt_count,
    output logic [31:0]                flit_count
);

    pkt_state_t            state_q, state_d;
    pkt_req_t              req_q, req_d;
    logic                  first_q, first_d;
    logic [PKT_ID_W-1:0]   pkt_id_q, pkt_id_d;
    logic                  req_err_q, req_err_d;
    logic [31:0]           pkt_count_q, pkt_count_d;
    logic [31:0]           flit_count_q, flit_count_d;

    logic      load;
    logic      can_load;
    logic      last;
    logic      req_illegal;
    logic      out_hs;
    noc_flit_t load_flit;

    // Compare one bit wider so a mesh dimension of 2^COORD_WIDTH does not wrap to zero
    assign req_illegal = ({1'b0, req_dest_x} >= (COORD_WIDTH + 1)'(MESH_SIZE_X))
                      || ({1'b0, req_dest_y} >= (COORD_WIDTH + 1)'(MESH_SIZE_Y))
                      || (req_len == '0)
                      || (req_len > LEN_W'(MAX_PKT_FLITS));

    assign last   = (req_q.len == PKT_LEN_W'(1));
    assign out_hs = flit_out_valid && flit_out_ready;

    always_comb begin
        load_flit.flit_type = flit_kind(first_q, last);
        load_flit.packet_id = pkt_id_q;
        load_flit.src_x     = COORD_WIDTH'(SRC_X);
        load_flit.src_y     = COORD_WIDTH'(SRC_Y);
        load_flit.dest_x    = req_q.dest_x;
        load_flit.dest_y    = req_q.dest_y;
        load_flit.vc_id     = req_q.vc;
        load_flit.payload   = data;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        first_d    = first_q;
        pkt_id_d   = pkt_id_q;
        req_err_d  = 1'b0;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        load       = 1'b0;
        case (state_q)
            PKT_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_illegal) begin
                        req_err_d = 1'b1;
                    end else begin
                        req_d.dest_x = req_dest_x;
                        req_d.dest_y = req_dest_y;
                        req_d.vc     = req_vc;
                        req_d.len    = PKT_LEN_W'(req_len);
                        first_d      = 1'b1;
                        state_d      = PKT_SEND;
                    end
                end
            end
            PKT_SEND: begin
                data_ready = can_load;
                load       = data_valid && can_load;
                if (load) begin
                    req_d.len = req_q.len - PKT_LEN_W'(1);
                    first_d   = 1'b0;
                    if (last) begin
                        pkt_id_d = pkt_id_q + PKT_ID_W'(1);
                        state_d  = PKT_IDLE;
                    end
                end
            end
            default: state_d = PKT_IDLE;
        endcase
    end

    // Counters follow the output handshake, not the load, so they only count flits the router took
    always_comb begin
        flit_count_d = flit_count_q;
        pkt_count_d  = pkt_count_q;
        if (out_hs) begin
            flit_count_d = flit_count_q + 32'd1;
            if (flit_out.flit_type == FLIT_TAIL || flit_out.flit_type == FLIT_SINGLE) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PKT_IDLE;
            req_q        <= '0;
            first_q      <= 1'b0;
            pkt_id_q     <= '0;
            req_err_q    <= 1'b0;
            pkt_count_q  <= '0;
            flit_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            first_q      <= first_d;
            pkt_id_q     <= pkt_id_d;
            req_err_q    <= req_err_d;
            pkt_count_q  <= pkt_count_d;
            flit_count_q <= flit_count_d;
        end
    end

    nebula_flit_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_flit (load_flit),
        .can_load  (can_load),
        .out_valid (flit_out_valid),
        .out_ready (flit_out_ready),
        .out_flit  (flit_out)
    );

    assign busy       = (state_q != PKT_IDLE) || flit_out_valid;
    assign req_err    = req_err_q;
    assign pkt_count  = pkt_count_q;
    assign flit_count = flit_count_q;

endmodule

// File: tb/tb_nebula_local_packetizer.sv
// tb/tb_nebula_local_packetizer.sv - directed per-cycle vector bench for nebula_local_packetizer
module tb_nebula_local_packetizer;
    import nebula_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest_x;
    logic [3:0]  req_dest_y;
    logic        req_vc;
    logic [4:0]  req_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic        flit_out_valid;
    logic        flit_out_ready;
    noc_flit_t   flit_out;
    logic        busy;
    logic        req_err;
    logic [31:0] pkt_count;
    logic [31:0] flit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nebula_local_packetizer #(
        .MESH_SIZE_X   (2),
        .MESH_SIZE_Y   (2),
        .SRC_X         (0),
        .SRC_Y         (0),
        .MAX_PKT_FLITS (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dest_x     (req_dest_x),
        .req_dest_y     (req_dest_y),
        .req_vc         (req_vc),
        .req_len        (req_len),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data           (data),
        .flit_out_valid (flit_out_valid),
        .flit_out_ready (flit_out_ready),
        .flit_out       (flit_out),
        .busy           (busy),
        .req_err        (req_err),
        .pkt_count      (pkt_count),
        .flit_count     (flit_count)
    );

    typedef struct {
        logic        rst, rv;
        logic [3:0]  dx, dy;
        logic        vc;
        logic [4:0]  len;
        logic        dv;
        logic [31:0] d;
        logic        ordy;
        logic        e_rr, e_dr, e_fv;
        flit_type_t  e_ft;
        logic [3:0]  e_dx, e_dy;
        logic        e_vc;
        logic [7:0]  e_pid;
        logic [31:0] e_pay;
        logic        e_err, e_busy;
        logic [31:0] e_pk, e_fl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rs, input int rv, input int dx, input int dy, input int vc,
                                input int len, input int dv, input int d, input int ordy,
                                input int rr, input int dr, input int fv, input flit_type_t ft,
                                input int edx, input int edy, input int evc, input int pid, input int pay,
                                input int err, input int bsy, input int pk, input int fl);
        vec_t v;
        v.rst = 1'(rs);   v.rv = 1'(rv);   v.dx = 4'(dx);    v.dy = 4'(dy);
        v.vc = 1'(vc);    v.len = 5'(len); v.dv = 1'(dv);    v.d = 32'(d);   v.ordy = 1'(ordy);
        v.e_rr = 1'(rr);  v.e_dr = 1'(dr); v.e_fv = 1'(fv);  v.e_ft = ft;
        v.e_dx = 4'(edx); v.e_dy = 4'(edy); v.e_vc = 1'(evc); v.e_pid = 8'(pid); v.e_pay = 32'(pay);
        v.e_err = 1'(err); v.e_busy = 1'(bsy); v.e_pk = 32'(pk); v.e_fl = 32'(fl);
        return v;
    endfunction

    function automatic logic [58:0] pack_flit(input flit_type_t ft, input logic [3:0] sx, input logic [3:0] sy,
                                             input logic [3:0] dx, input logic [3:0] dy, input logic vc,
                                             input logic [7:0] pid, input logic [31:0] pay);
        return {ft, sx, sy, dx, dy, vc, pid, pay};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [58:0] actual_flit();
        return pack_flit(flit_out.flit_type, flit_out.src_x, flit_out.src_y, flit_out.dest_x,
                         flit_out.dest_y, flit_out.vc_id, flit_out.packet_id, flit_out.payload);
    endfunction

    initial begin
        logic [127:0] got, exp;
        logic [58:0]  ef;

        //        rst rv dx dy vc len dv d      ordy | rr dr fv ft           dx dy vc pid pay    err bsy pk fl
        vecs.push_back(mk(0, 1, 1, 0, 0, 1,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'hA5,   1,  0, 1, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 1, FLIT_SINGLE, 1, 0, 0, 0, 'hA5,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 1, 1));
        // four-flit packet, vc 1, dest (0,1), then back-to-back request
        vecs.push_back(mk(0, 1, 0, 1, 1, 4,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1,      1,  0, 1, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2,      1,  0, 1, 1, FLIT_HEAD,   0, 1, 1, 1, 1,      0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 3,      1,  0, 1, 1, FLIT_BODY,   0, 1, 1, 1, 2,      0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 4,      1,  0, 1, 1, FLIT_BODY,   0, 1, 1, 1, 3,      0, 1, 1, 3));
        vecs.push_back(mk(0, 1, 1, 1, 0, 3,  0, 0,      1,  1, 0, 1, FLIT_TAIL,   0, 1, 1, 1, 4,      0, 1, 1, 4));
        // three-flit packet with 3 cycles of backpressure on the HEAD
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h10,   1,  0, 1, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 1, 2, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h11,   0,  0, 0, 1, FLIT_HEAD,   1, 1, 0, 2, 'h10,   0, 1, 2, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h11,   0,  0, 0, 1, FLIT_HEAD,   1, 1, 0, 2, 'h10,   0, 1, 2, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h11,   0,  0, 0, 1, FLIT_HEAD,   1, 1, 0, 2, 'h10,   0, 1, 2, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h11,   1,  0, 1, 1, FLIT_HEAD,   1, 1, 0, 2, 'h10,   0, 1, 2, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h12,   1,  0, 1, 1, FLIT_BODY,   1, 1, 0, 2, 'h11,   0, 1, 2, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      0,  1, 0, 1, FLIT_TAIL,   1, 1, 0, 2, 'h12,   0, 1, 2, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 1, FLIT_TAIL,   1, 1, 0, 2, 'h12,   0, 1, 2, 7));
        // illegal requests: dest x out of mesh, len 0, len above max
        vecs.push_back(mk(0, 1, 2, 0, 0, 1,  1, 'h77,   1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 3, 8));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 'h77,   1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      1, 0, 3, 8));
        vecs.push_back(mk(0, 1, 1, 0, 0, 17, 1, 'h77,   1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      1, 0, 3, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      1, 0, 3, 8));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 3, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'hAB,   1,  0, 1, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 1, 3, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'hCD,   1,  0, 1, 1, FLIT_HEAD,   1, 1, 1, 3, 'hAB,   0, 1, 3, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 1, FLIT_TAIL,   1, 1, 1, 3, 'hCD,   0, 1, 3, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 4, 10));
        // reset after the HEAD of a len-8 packet, then a len-2 packet restarts at id 0
        vecs.push_back(mk(0, 1, 1, 0, 0, 8,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 4, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h50,   1,  0, 1, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 1, 4, 10));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 'h51,   0,  0, 0, 1, FLIT_HEAD,   1, 0, 0, 4, 'h50,   0, 1, 4, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 2,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h60,   1,  0, 1, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 'h61,   1,  0, 1, 1, FLIT_HEAD,   1, 1, 0, 0, 'h60,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 1, FLIT_TAIL,   1, 1, 0, 0, 'h61,   0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1,  1, 0, 0, FLIT_HEAD,   0, 0, 0, 0, 0,      0, 0, 1, 2));

        rst = 1'b1; req_valid = 1'b0; req_dest_x = '0; req_dest_y = '0; req_vc = 1'b0; req_len = '0;
        data_valid = 1'b0; data = '0; flit_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state",
              {req_ready, data_ready, flit_out_valid, req_err, busy, pkt_count, flit_count, actual_flit()},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 59'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            req_valid  = vecs[i].rv;
            req_dest_x = vecs[i].dx;
            req_dest_y = vecs[i].dy;
            req_vc     = vecs[i].vc;
            req_len    = vecs[i].len;
            data_valid = vecs[i].dv;
            data       = vecs[i].d;
            flit_out_ready = vecs[i].ordy;
            #1;
            ef  = vecs[i].e_fv ? pack_flit(vecs[i].e_ft, 4'd0, 4'd0, vecs[i].e_dx, vecs[i].e_dy,
                                           vecs[i].e_vc, vecs[i].e_pid, vecs[i].e_pay) : 59'd0;
            got = {req_ready, data_ready, flit_out_valid, req_err, busy, pkt_count, flit_count,
                   vecs[i].e_fv ? actual_flit() : 59'd0};
            exp = {vecs[i].e_rr, vecs[i].e_dr, vecs[i].e_fv, vecs[i].e_err, vecs[i].e_busy,
                   vecs[i].e_pk, vecs[i].e_fl, ef};
            check($sformatf("vec%0d", i), got, exp);
        end

        // packet id wrap: 257 single-flit packets from a fresh reset
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; data_valid = 1'b0; flit_out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] exp_id;
            exp_id = 8'(i);
            @(negedge clk);
            req_valid = 1'b1; req_dest_x = 4'd1; req_dest_y = 4'd0; req_vc = 1'b0; req_len = 5'd1;
            @(negedge clk);
            req_valid = 1'b0; data_valid = 1'b1; data = 32'(i);
            @(negedge clk);
            data_valid = 1'b0;
            #1;
            check($sformatf("wrap_pkt%0d", i),
                  {flit_out_valid, flit_out.flit_type, flit_out.packet_id, flit_out.payload},
                  {1'b1, FLIT_SINGLE, exp_id, 32'(i)});
        end
        @(negedge clk);
        #1;
        check("wrap_counts", {flit_out_valid, pkt_count, flit_count}, {1'b0, 32'd257, 32'd257});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
